// File: rtl/pe_add_arbiter.sv
// pe_add_arbiter: round-robin sharing of one WIDTH-bit adder among NREQ requesters, single-entry result stage.
// Latency: a request accepted at edge N is presented on rsp_* in cycle N+1; one result per cycle sustained.
// Backpressure: a held result with rsp_ready=0 blocks every grant; clk_en=0 freezes state and masks rsp_valid.
// Build option: define PE_ADD_ARB_FLAGS_EN to include {V,N,Z,C} flag logic; otherwise rsp_flags reads 0.
module pe_add_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                   CLK,
    input  logic                   ASYNCRESET,
    input  logic                   clk_en,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*WIDTH-1:0]  req_a,
    input  logic [NREQ*WIDTH-1:0]  req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [IDW-1:0]         rsp_id,
    output logic [3:0]             rsp_flags,
    output logic [15:0]            ops_count
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   gnt_idx;
    logic             gnt_found;
    logic             slot_free;
    logic             accept;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   sum_full;

    // The slot can take a new result when empty or when the held one drains this same cycle.
    assign slot_free = clk_en && ((state == EMPTY) || rsp_ready);

    // Rotating priority search starting at ptr; first valid requester wins.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!gnt_found && req_valid[IDW'(idx)]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(idx);
            end
        end
    end

    // Reset must also silence the grant, since ready is purely combinational.
    assign accept    = slot_free && gnt_found && !ASYNCRESET;
    assign req_ready = accept ? (NREQ'(1) << gnt_idx) : '0;

    // Route the winner's operands to the shared adder.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                op_a = req_a[i*WIDTH +: WIDTH];
                op_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Zero-extended add keeps the carry out in the top bit.
    assign sum_full = {1'b0, op_a} + {1'b0, op_b};

    // Output-stage FSM, result register, rotation pointer and accept counter.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state     <= EMPTY;
            ptr       <= '0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            ops_count <= '0;
        end else if (clk_en) begin
            if (accept) begin
                state     <= FULL;
                rsp_data  <= sum_full[WIDTH-1:0];
                rsp_id    <= gnt_idx;
                ptr       <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
                ops_count <= ops_count + 16'd1;
            end else if ((state == FULL) && rsp_ready) begin
                state <= EMPTY;
            end
        end
    end

    // With clk_en low the result is hidden so downstream cannot drain it.
    assign rsp_valid = (state == FULL) && clk_en;

`ifdef PE_ADD_ARB_FLAGS_EN
    logic       a_msb;
    logic       b_msb;
    logic       s_msb;
    logic [3:0] flags_d;

    assign a_msb   = op_a[WIDTH-1];
    assign b_msb   = op_b[WIDTH-1];
    assign s_msb   = sum_full[WIDTH-1];
    assign flags_d = {(a_msb & b_msb & ~s_msb) | (~a_msb & ~b_msb & s_msb),
                      s_msb,
                      (sum_full[WIDTH-1:0] == '0),
                      sum_full[WIDTH]};

    // Flags are captured alongside the data so they stay aligned with it.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            rsp_flags <= 4'b0000;
        end else if (clk_en && accept) begin
            rsp_flags <= flags_d;
        end
    end
`else
    assign rsp_flags = 4'b0000;
`endif

endmodule

// File: tb/tb_pe_add_arbiter.sv
// tb_pe_add_arbiter: directed and randomized checks of pe_add_arbiter against a behavioural model.
// Latency: model state advances once per clock, mirroring the one-cycle result stage.
// Backpressure: random rsp_ready and clk_en; requesters hold valid/operands until granted.
module tb_pe_add_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int IDW  = 2;

`ifdef PE_ADD_ARB_FLAGS_EN
    localparam logic [3:0] FLAGS_OVF  = 4'b1100;
    localparam logic [3:0] FLAGS_WRAP = 4'b0011;
`else
    localparam logic [3:0] FLAGS_OVF  = 4'b0000;
    localparam logic [3:0] FLAGS_WRAP = 4'b0000;
`endif

    logic                CLK = 1'b0;
    logic                ASYNCRESET;
    logic                clk_en;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*W-1:0]   req_a;
    logic [NREQ*W-1:0]   req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [W-1:0]        rsp_data;
    logic [IDW-1:0]      rsp_id;
    logic [3:0]          rsp_flags;
    logic [15:0]         ops_count;

    logic [W-1:0]        a_op [NREQ];
    logic [W-1:0]        b_op [NREQ];
    bit                  pend [NREQ];

    int checks;
    int failures;

    // Behavioural model of the visible state
    int m_ptr;
    bit m_full;
    int m_data;
    int m_id;
    int m_flags;
    int m_cnt;
    int last_gnt;

    pe_add_arbiter #(.NREQ(NREQ), .WIDTH(W)) dut (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .clk_en     (clk_en),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_flags  (rsp_flags),
        .ops_count  (ops_count)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = a_op[i];
            req_b[i*W +: W] = b_op[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Flags from two's-complement arithmetic on plain integers.
    function automatic int exp_flags(input int a, input int b);
`ifdef PE_ADD_ARB_FLAGS_EN
        int s, r, sa, sb, ss, f;
        s  = a + b;
        r  = s % 65536;
        sa = (a >= 32768) ? a - 65536 : a;
        sb = (b >= 32768) ? b - 65536 : b;
        ss = sa + sb;
        f  = 0;
        if (ss > 32767 || ss < -32768) f += 8;
        if (r >= 32768)                f += 4;
        if (r == 0)                    f += 2;
        if (s >= 65536)                f += 1;
        return f;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_full = 0; m_data = 0; m_id = 0; m_flags = 0; m_cnt = 0;
    endtask

    // Called at posedge+1 with inputs settled; checks before the next edge, then advances the model.
    task automatic step();
        int g;
        int idx;
        logic [NREQ-1:0] exp_rdy;
        #4;
        g = -1;
        if (clk_en && (!m_full || rsp_ready)) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_full && clk_en));
        chk("rsp_data",  32'(rsp_data),  m_data);
        chk("rsp_id",    32'(rsp_id),    m_id);
        chk("rsp_flags", 32'(rsp_flags), m_flags);
        chk("ops_count", 32'(ops_count), m_cnt);
        if (clk_en) begin
            if (g >= 0) begin
                m_data  = (int'(a_op[g]) + int'(b_op[g])) % 65536;
                m_flags = exp_flags(int'(a_op[g]), int'(b_op[g]));
                m_id    = g;
                m_full  = 1;
                m_ptr   = (g + 1) % NREQ;
                m_cnt   = (m_cnt + 1) % 65536;
            end else if (m_full && rsp_ready) begin
                m_full = 0;
            end
        end
        last_gnt = g;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        checks   = 0;
        failures = 0;
        last_gnt = -1;
        for (int i = 0; i < NREQ; i++) begin
            a_op[i] = W'(i + 1);
            b_op[i] = W'(16 * i);
            pend[i] = 0;
        end
        ASYNCRESET = 1'b1;
        clk_en     = 1'b1;
        rsp_ready  = 1'b1;
        req_valid  = '1;
        #2;
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_ops",   32'(ops_count), 0);
        chk("rst_data",  32'(rsp_data),  0);
        chk("rst_id",    32'(rsp_id),    0);
        chk("rst_flags", 32'(rsp_flags), 0);
        @(posedge CLK);
        #1;
        chk("rst_ready_edge", 32'(req_ready), 0);
        ASYNCRESET = 1'b0;
        model_reset();

        // Round robin with everyone valid: 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rr_grant", 32'(last_gnt), 32'(i % NREQ));
            chk("rr_id",    32'(rsp_id),   32'(i % NREQ));
        end
        chk("rr_ops5", 32'(ops_count), 5);

        // Signed overflow from requester 2
        req_valid = 4'b0100;
        a_op[2] = 16'h7FFF; b_op[2] = 16'h0001;
        step();
        chk("ovf_data",  32'(rsp_data),  32'h8000);
        chk("ovf_id",    32'(rsp_id),    2);
        chk("ovf_flags", 32'(rsp_flags), 32'(FLAGS_OVF));
        // Carry-out wrap from requester 1
        req_valid = 4'b0010;
        a_op[1] = 16'hFFFF; b_op[1] = 16'h0001;
        step();
        chk("wrap_data",  32'(rsp_data),  0);
        chk("wrap_id",    32'(rsp_id),    1);
        chk("wrap_flags", 32'(rsp_flags), 32'(FLAGS_WRAP));

        // Move ptr to 0 and empty the slot
        req_valid = 4'b1000;
        step();
        req_valid = 4'b0000;
        step();

        // Backpressure: requesters 0 and 3, downstream stalled
        req_valid = 4'b1001;
        rsp_ready = 1'b0;
        step();
        chk("bp_first", 32'(last_gnt), 0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_nogrant", 32'(last_gnt), 32'(-1));
        end
        chk("bp_hold_id", 32'(rsp_id), 0);
        rsp_ready = 1'b1;
        step();
        chk("bp_release", 32'(last_gnt), 3);
        chk("bp_next_id", 32'(rsp_id), 3);
        req_valid = 4'b0001;
        step();
        req_valid = 4'b0000;

        // clk_en low while FULL: hidden and frozen, then reappears
        clk_en    = 1'b0;
        req_valid = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("en_nogrant", 32'(last_gnt), 32'(-1));
        end
        chk("en_hidden", 32'(rsp_valid), 0);
        clk_en    = 1'b1;
        rsp_ready = 1'b0;
        step();
        chk("en_back_id", 32'(rsp_id), 0);
        rsp_ready = 1'b1;
        step();
        chk("en_drain_grant", 32'(last_gnt), 1);
        req_valid = 4'b0000;

        // Asynchronous reset between edges while FULL
        #2;
        ASYNCRESET = 1'b1;
        req_valid  = '1;
        #1;
        chk("arst_valid", 32'(rsp_valid), 0);
        chk("arst_ops",   32'(ops_count), 0);
        chk("arst_ready", 32'(req_ready), 0);
        #1;
        ASYNCRESET = 1'b0;
        model_reset();
        #0;
        chk("arst_ptr0", 32'(req_ready), 1);
        step();
        req_valid = '0;

        // Randomized traffic with held requests
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pend[i] = 1;
                    case ($urandom_range(0, 3))
                        0:       a_op[i] = 16'h7FFF;
                        1:       a_op[i] = 16'hFFFF;
                        default: a_op[i] = W'($urandom);
                    endcase
                    b_op[i] = ($urandom_range(0, 3) == 0) ? 16'h0001 : W'($urandom);
                end
                req_valid[i] = pend[i];
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            clk_en    = ($urandom_range(0, 7) != 0);
            step();
            if (last_gnt >= 0) pend[last_gnt] = 0;
        end

        // Counter wrap: 65537 accepts from reset
        clk_en    = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '1;
        ASYNCRESET = 1'b1;
        #1;
        ASYNCRESET = 1'b0;
        repeat (65537) @(posedge CLK);
        #1;
        chk("ops_wrap", 32'(ops_count), 1);
        chk("ops_wrap_id", 32'(rsp_id), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
